// File: rtl/fadd_pkg.sv
// Shared constants and the stage-2 output bundle for the N32 adder front end.
// Reused by fadd_prep_n32 and the close/far path wrappers.
package fadd_pkg;
    localparam int FADD_FRAC_W    = 32;
    localparam int FADD_EXP_W     = 8;
    localparam int FADD_SHIFT_W   = 6;
    localparam int FADD_SHIFT_SAT = FADD_FRAC_W + 2;

    typedef struct packed {
        logic                    close_sel;
        logic                    exp_a_neq_b;
        logic                    far_sign;
        logic [FADD_EXP_W-1:0]   exp_f;
        logic [FADD_FRAC_W-1:0]  elarge;
        logic [FADD_FRAC_W-1:0]  esmall;
        logic [FADD_SHIFT_W-1:0] far_shift;
    } fadd_prep_t;
endpackage

// File: rtl/fadd_exp_cmp.sv
// Combinational exponent compare: both-direction differences, borrow and
// saturated alignment shifts for each ordering.
module fadd_exp_cmp #(
    parameter int EXP_W     = 8,
    parameter int SHIFT_W   = 6,
    parameter int SHIFT_SAT = 34
) (
    input  logic [EXP_W-1:0]   i_exp_a,
    input  logic [EXP_W-1:0]   i_exp_b,
    output logic [EXP_W:0]     o_diff_ab,
    output logic [EXP_W:0]     o_diff_ba,
    output logic               o_b_gt_a,
    output logic [SHIFT_W-1:0] o_shift_ab,
    output logic [SHIFT_W-1:0] o_shift_ba
);
    localparam logic [EXP_W:0]   SAT_X = (EXP_W+1)'(SHIFT_SAT);
    localparam logic [SHIFT_W-1:0] SAT_S = SHIFT_W'(SHIFT_SAT);

    assign o_diff_ab = {1'b0, i_exp_a} - {1'b0, i_exp_b};
    assign o_diff_ba = {1'b0, i_exp_b} - {1'b0, i_exp_a};
    assign o_b_gt_a  = o_diff_ab[EXP_W];

    // A negative difference reads as huge and saturates; it is never selected.
    assign o_shift_ab = (o_diff_ab > SAT_X) ? SAT_S : o_diff_ab[SHIFT_W-1:0];
    assign o_shift_ba = (o_diff_ba > SAT_X) ? SAT_S : o_diff_ba[SHIFT_W-1:0];
endmodule

// File: rtl/fadd_prep_n32.sv
// Two-stage pre-alignment for the N32 adder: compare, then swap/select path.
// Optional FADD_PREP_ZERO_BYPASS_EN adds o_zero_bypass for zero-exponent operands.
module fadd_prep_n32
    import fadd_pkg::*;
#(
    parameter int FRAC_WIDTH  = FADD_FRAC_W,
    parameter int EXP_WIDTH   = FADD_EXP_W,
    parameter int SHIFT_WIDTH = FADD_SHIFT_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic                   i_op_sub,
    input  logic                   i_sign_a,
    input  logic                   i_sign_b,
    input  logic [EXP_WIDTH-1:0]   i_exp_a,
    input  logic [EXP_WIDTH-1:0]   i_exp_b,
    input  logic [FRAC_WIDTH-1:0]  i_frac_a,
    input  logic [FRAC_WIDTH-1:0]  i_frac_b,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic                   o_close_sel,
    output logic                   o_exp_a_neq_b,
    output logic                   o_far_sign,
    output logic [EXP_WIDTH-1:0]   o_exp_f,
    output logic [FRAC_WIDTH-1:0]  o_elarge_op32,
    output logic [FRAC_WIDTH-1:0]  o_esmall_op32,
    output logic [SHIFT_WIDTH-1:0] o_far_shift
`ifdef FADD_PREP_ZERO_BYPASS_EN
    ,output logic                  o_zero_bypass
`endif
);
    localparam logic [SHIFT_WIDTH-1:0] SAT_S = SHIFT_WIDTH'(FADD_SHIFT_SAT);
    localparam logic [EXP_WIDTH:0]     ONE_X = (EXP_WIDTH+1)'(1);

    logic r_v1, r_v2;
    logic w_adv1, w_in_ready, w_load1, w_load2;

    logic                   r1_sign_a, r1_sign_b_eff, r1_eff_sub, r1_b_gt_a;
    logic [EXP_WIDTH-1:0]   r1_exp_a, r1_exp_b;
    logic [FRAC_WIDTH-1:0]  r1_frac_a, r1_frac_b;
    logic [EXP_WIDTH:0]     r1_diff_ab, r1_diff_ba;
    logic [SHIFT_WIDTH-1:0] r1_shift_ab, r1_shift_ba;

    logic [EXP_WIDTH:0]     w_diff_ab, w_diff_ba;
    logic                   w_b_gt_a;
    logic [SHIFT_WIDTH-1:0] w_shift_ab, w_shift_ba;
    logic                   w_sign_b_eff;

    fadd_prep_t r2_out, w_nxt;
    logic [EXP_WIDTH:0] w_d;
`ifdef FADD_PREP_ZERO_BYPASS_EN
    logic r2_zero_bypass, w_zero;
`endif

    assign w_adv1     = ~r_v2 | i_out_ready;
    assign w_in_ready = ~r_v1 | w_adv1;
    assign o_in_ready = w_in_ready | i_rst;
    assign w_load1    = i_in_valid & w_in_ready & ~i_flush;
    assign w_load2    = r_v1 & w_adv1 & ~i_flush;
    assign w_sign_b_eff = i_sign_b ^ i_op_sub;

    fadd_exp_cmp #(
        .EXP_W    (EXP_WIDTH),
        .SHIFT_W  (SHIFT_WIDTH),
        .SHIFT_SAT(FADD_SHIFT_SAT)
    ) u_cmp (
        .i_exp_a   (i_exp_a),
        .i_exp_b   (i_exp_b),
        .o_diff_ab (w_diff_ab),
        .o_diff_ba (w_diff_ba),
        .o_b_gt_a  (w_b_gt_a),
        .o_shift_ab(w_shift_ab),
        .o_shift_ba(w_shift_ba)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1          <= 1'b0;
            r1_sign_a     <= 1'b0;
            r1_sign_b_eff <= 1'b0;
            r1_eff_sub    <= 1'b0;
            r1_b_gt_a     <= 1'b0;
            r1_exp_a      <= '0;
            r1_exp_b      <= '0;
            r1_frac_a     <= '0;
            r1_frac_b     <= '0;
            r1_diff_ab    <= '0;
            r1_diff_ba    <= '0;
            r1_shift_ab   <= '0;
            r1_shift_ba   <= '0;
        end else begin
            if (i_flush)         r_v1 <= 1'b0;
            else if (w_in_ready) r_v1 <= i_in_valid;
            if (w_load1) begin
                r1_sign_a     <= i_sign_a;
                r1_sign_b_eff <= w_sign_b_eff;
                r1_eff_sub    <= i_sign_a ^ w_sign_b_eff;
                r1_b_gt_a     <= w_b_gt_a;
                r1_exp_a      <= i_exp_a;
                r1_exp_b      <= i_exp_b;
                r1_frac_a     <= i_frac_a;
                r1_frac_b     <= i_frac_b;
                r1_diff_ab    <= w_diff_ab;
                r1_diff_ba    <= w_diff_ba;
                r1_shift_ab   <= w_shift_ab;
                r1_shift_ba   <= w_shift_ba;
            end
        end
    end

    // Equal exponents keep A as large; downstream borrow settles magnitude.
    always_comb begin
        w_d               = r1_b_gt_a ? r1_diff_ba : r1_diff_ab;
        w_nxt             = '0;
        w_nxt.exp_f       = r1_b_gt_a ? r1_exp_b : r1_exp_a;
        w_nxt.far_sign    = r1_b_gt_a ? r1_sign_b_eff : r1_sign_a;
        w_nxt.elarge      = r1_b_gt_a ? r1_frac_b : r1_frac_a;
        w_nxt.esmall      = r1_b_gt_a ? r1_frac_a : r1_frac_b;
        w_nxt.far_shift   = r1_b_gt_a ? r1_shift_ba : r1_shift_ab;
        w_nxt.exp_a_neq_b = (w_d == ONE_X);
        w_nxt.close_sel   = r1_eff_sub & (w_d <= ONE_X);
`ifdef FADD_PREP_ZERO_BYPASS_EN
        // Ordering already puts a nonzero exponent on the large side.
        w_zero = (r1_exp_a == '0) | (r1_exp_b == '0);
        if (w_zero) begin
            w_nxt.close_sel = 1'b0;
            w_nxt.far_shift = SAT_S;
            if ((r1_exp_a == '0) && (r1_exp_b == '0))
                w_nxt.far_sign = r1_sign_a & r1_sign_b_eff;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v2   <= 1'b0;
            r2_out <= '0;
`ifdef FADD_PREP_ZERO_BYPASS_EN
            r2_zero_bypass <= 1'b0;
`endif
        end else begin
            if (i_flush)     r_v2 <= 1'b0;
            else if (w_adv1) r_v2 <= r_v1;
            if (w_load2) begin
                r2_out <= w_nxt;
`ifdef FADD_PREP_ZERO_BYPASS_EN
                r2_zero_bypass <= w_zero;
`endif
            end
        end
    end

    assign o_out_valid   = r_v2;
    assign o_close_sel   = r2_out.close_sel;
    assign o_exp_a_neq_b = r2_out.exp_a_neq_b;
    assign o_far_sign    = r2_out.far_sign;
    assign o_exp_f       = r2_out.exp_f;
    assign o_elarge_op32 = r2_out.elarge;
    assign o_esmall_op32 = r2_out.esmall;
    assign o_far_shift   = r2_out.far_shift;
`ifdef FADD_PREP_ZERO_BYPASS_EN
    assign o_zero_bypass = r2_zero_bypass;
`endif
endmodule
